// File: rtl/uart_mmio_if.sv
// ----------------------------------------------------------------------------
// uart_mmio_if
// Purpose : CPU data-bus slice seen by the memory-mapped UART. It bundles the
//           request side (ce/we/addr/sel/wdata) driven by the bus initiator
//           and the response side (read data, address-hit flag) driven back
//           by the UART.
// Signals : mem_ce      access valid this cycle
//           mem_we      1 = write, 0 = read
//           mem_addr_i  32-bit byte address
//           mem_sel     byte enables (bit 0 qualifies data writes)
//           mem_data_i  write data, byte [7:0] used
//           ram_data_o  read data returned by the UART
//           uart_hit_o  UART claims this access
// ----------------------------------------------------------------------------
interface uart_mmio_if;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel;
    logic [31:0] mem_data_i;
    logic [31:0] ram_data_o;
    logic        uart_hit_o;

    modport master (
        output mem_ce, mem_we, mem_addr_i, mem_sel, mem_data_i,
        input  ram_data_o, uart_hit_o
    );

    modport slave (
        input  mem_ce, mem_we, mem_addr_i, mem_sel, mem_data_i,
        output ram_data_o, uart_hit_o
    );
endinterface

// File: rtl/uart_mmio.sv
// ----------------------------------------------------------------------------
// uart_mmio
// Purpose : Memory-mapped UART on the CPU data bus. A write to DATA_ADDR
//           sends one 8N1 frame on txd; a frame received on rxd is held in a
//           one-byte buffer readable at DATA_ADDR; STAT_ADDR reports
//           {overrun, rx_valid, tx_ready}. Reads are combinational.
// Ports   : clk         system clock
//           rst         asynchronous active-high reset
//           bus         uart_mmio_if.slave (mem_* request, ram_data_o/uart_hit_o)
//           txd         serial output, idle high
//           rxd         serial input, asynchronous to clk
// ----------------------------------------------------------------------------
module uart_mmio #(
    parameter int          CLK_FREQ  = 60000000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] DATA_ADDR = 32'hBFD003F8,
    parameter logic [31:0] STAT_ADDR = 32'hBFD003FC
) (
    input  logic       clk,
    input  logic       rst,
    uart_mmio_if.slave bus,
    output logic       txd,
    input  logic       rxd
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_Z   = CW'(0);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} ser_state_t;

    // ---------------- bus decode ----------------
    logic data_hit_s, stat_hit_s, rd_data_s, wr_accept_s, tx_ready_s;
    ser_state_t tx_state_r, tx_state_s, rx_state_r, rx_state_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_s, rx_cnt_r, rx_cnt_s;
    logic [2:0]    tx_bit_r, tx_bit_s, rx_bit_r, rx_bit_s;
    logic [7:0]    tx_shift_r, tx_shift_s, rx_shift_r, rx_shift_s;
    logic          txd_r, txd_s, commit_s;
    logic          rx_meta_r, rxs_r;
    logic [7:0]    rx_byte_r;
    logic          rx_valid_r, overrun_r;

    // Address decode, access qualification and read-data mux.
    always_comb begin
        data_hit_s  = bus.mem_ce && (bus.mem_addr_i == DATA_ADDR);
        stat_hit_s  = bus.mem_ce && (bus.mem_addr_i == STAT_ADDR);
        tx_ready_s  = (tx_state_r == S_IDLE);
        rd_data_s   = data_hit_s && !bus.mem_we;
        wr_accept_s = data_hit_s && bus.mem_we && bus.mem_sel[0] && tx_ready_s;
        bus.uart_hit_o = data_hit_s || stat_hit_s;
        if (data_hit_s) begin
            bus.ram_data_o = {24'h000000, rx_byte_r};
        end else if (stat_hit_s) begin
            bus.ram_data_o = {29'h00000000, overrun_r, rx_valid_r, tx_ready_s};
        end else begin
            bus.ram_data_o = 32'h00000000;
        end
    end

    // ---------------- transmitter ----------------
    // TX next state: the counter runs DIV-1..0 per bit; txd is registered so
    // it changes on the same edge the state enters a new bit.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        txd_s      = txd_r;
        case (tx_state_r)
            S_IDLE: begin
                if (wr_accept_s) begin
                    tx_state_s = S_START;
                    tx_cnt_s   = DIV_M1;
                    tx_shift_s = bus.mem_data_i[7:0];
                    txd_s      = 1'b0;
                end else begin
                    txd_s      = 1'b1;
                end
            end
            S_START: begin
                if (tx_cnt_r == CNT_Z) begin
                    tx_state_s = S_DATA;
                    tx_cnt_s   = DIV_M1;
                    tx_bit_s   = 3'd0;
                    txd_s      = tx_shift_r[0];
                end else begin
                    tx_cnt_s   = tx_cnt_r - CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_r == CNT_Z) begin
                    tx_cnt_s = DIV_M1;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = S_STOP;
                        txd_s      = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        txd_s      = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r - CW'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt_r == CNT_Z) begin
                    tx_state_s = S_IDLE;
                end else begin
                    tx_cnt_s   = tx_cnt_r - CW'(1);
                end
            end
            default: begin
                tx_state_s = S_IDLE;
                txd_s      = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= S_IDLE;
            tx_cnt_r   <= CNT_Z;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            txd_r      <= txd_s;
        end
    end

    assign txd = txd_r;

    // ---------------- receiver ----------------
    // Two-flop synchronizer for the asynchronous rxd line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rxs_r     <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rxs_r     <= rx_meta_r;
        end
    end

    // RX next state: a half-bit wait after the falling edge puts every later
    // sample in mid-bit; the line is re-armed right after the stop sample.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        commit_s   = 1'b0;
        case (rx_state_r)
            S_IDLE: begin
                if (!rxs_r) begin
                    rx_state_s = S_START;
                    rx_cnt_s   = HALF_M1;
                end else begin
                    rx_cnt_s   = CNT_Z;
                end
            end
            S_START: begin
                if (rx_cnt_r == CNT_Z) begin
                    if (rxs_r) begin
                        rx_state_s = S_IDLE;
                    end else begin
                        rx_state_s = S_DATA;
                        rx_cnt_s   = DIV_M1;
                        rx_bit_s   = 3'd0;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_r == CNT_Z) begin
                    rx_shift_s = {rxs_r, rx_shift_r[7:1]};
                    rx_cnt_s   = DIV_M1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = S_STOP;
                    end else begin
                        rx_bit_s   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - CW'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_r == CNT_Z) begin
                    rx_state_s = S_IDLE;
                    commit_s   = rxs_r;
                end else begin
                    rx_cnt_s   = rx_cnt_r - CW'(1);
                end
            end
            default: begin
                rx_state_s = S_IDLE;
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= S_IDLE;
            rx_cnt_r   <= CNT_Z;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // Receive buffer and flags. A commit beats a same-edge DATA read: the
    // new byte stays valid and overrun keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else if (commit_s) begin
            rx_byte_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
            if (!rd_data_s) begin
                overrun_r <= overrun_r | rx_valid_r;
            end
        end else if (rd_data_s) begin
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end
    end
endmodule
